ifetcher: RTL and testbench
===========================

# ifetcher

Instruction fetch unit for the out-of-order RISC-V core. It supplies the issue stage with one decoded-ready instruction per cycle through a valid/accept handshake. It runs a direct-mapped instruction cache, fills misses over a request/done handshake with the memory controller, and predicts branches with a 2-bit BHT. It redirects on a ROB flush.

## Interface
- `ICACHE_LINES`, 256: direct-mapped lines, one 32-bit word each, power of two.
- `BHT_ENTRIES`, 256: 2-bit saturating counters, power of two.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `rdy` in 1: global enable; when low, all state and registered outputs hold and `IS_ins_sgn` = 0.
- `ROB_full`, `LSB_full`, `RS_full` in 1 each: issue-side backpressure.
- `IS_ins_sgn` out 1: instruction offered **and** accepted this cycle.
- `IS_ins` out 32: instruction word.
- `IS_jump_flag` out 1: predicted-taken flag (branches); 0 otherwise.
- `IS_jump_pc` out 32: per-opcode address, defined under Operation.
- `MC_req` out 1: memory word-read request.
- `MC_addr` out 32: word-aligned read address.
- `MC_done` in 1: one-cycle pulse; `MC_data` is valid.
- `MC_data` in 32: fetched word.
- `ROB_clear` in 1: flush pulse.
- `ROB_newpc` in 32: restart PC, valid with `ROB_clear`.
- `ROB_br_sgn` in 1: branch-resolve pulse.
- `ROB_br_pc` in 32: resolved branch PC.
- `ROB_br_taken` in 1: resolved direction.

## Operation
- **Output slot.** The output slot is a register holding `valid`, `ins`, `jump_flag` and `jump_pc`.
  - `IS_ins_sgn = valid & rdy & !ROB_full & !LSB_full & !RS_full` (combinational).
  - A high `IS_ins_sgn` means the issue stage consumed the slot. Under backpressure the slot holds unchanged.
- **State machine.** States are FETCH, MISS and JALR_WAIT.
- **FETCH.**
  - Index = `pc[log2(ICACHE_LINES)+1:2]`; the tag is the remaining upper bits.
  - On a hit, when the slot is empty or consumed this cycle, load the slot and advance `pc`.
  - On a miss, go to MISS with `MC_req`=1 and `MC_addr`=`pc`.
- **MISS.**
  - Hold `MC_req` and `MC_addr` stable until `MC_done`.
  - On `MC_done`, write the line (data, tag, valid), deassert `MC_req`, and return to FETCH.
  - The word is not bypassed; it is re-looked-up as a hit the next cycle.
- **Predecode** of the instruction loaded into the slot (imm sign-extended, B/J imm LSB = 0):
  - JAL: next pc = pc + J-imm; `jump_pc` = pc+4.
  - Branch (op 1100011): the BHT counter at index `pc[log2(BHT_ENTRIES)+1:2]` predicts; taken when the counter's MSB = 1.
    - Taken: next pc = pc + B-imm, `jump_flag`=1, `jump_pc`=pc+4.
    - Not taken: next pc = pc+4, `jump_flag`=0, `jump_pc`=pc + B-imm. `jump_pc` is always the mispredict redirect target.
  - JALR: `jump_pc` = pc+4; go to JALR_WAIT; no further fetch.
  - AUIPC: `jump_pc` = pc.
  - All others: `jump_pc` = pc+4; next pc = pc+4.
- **JALR_WAIT.** Idle until `ROB_clear`.
- **ROB_clear.** Has priority over every other event, in any state:
  - `pc` ← `ROB_newpc`; slot `valid` ← 0; `MC_req` ← 0; state ← FETCH.
  - A `MC_done` in the same cycle is discarded and no cache write occurs.
  - The memory controller aborts when `MC_req` drops.
  - Cache and BHT contents are retained.
- **BHT update.** On `ROB_br_sgn`, update the counter at `ROB_br_pc` index: +1 saturating at 3 if taken, -1 saturating at 0 if not. This happens even in a `ROB_clear` cycle.
- **Reset values.**
  - `pc`=0, state FETCH, slot `valid`=0.
  - `IS_ins`=0, `IS_jump_flag`=0, `IS_jump_pc`=0, `MC_req`=0, `MC_addr`=0.
  - All cache valid bits=0; all BHT counters=2'b01.
  - Reset mid-miss drops `MC_req` on the next edge.

## Timing
- Hit-to-slot takes 1 cycle; sustained throughput is 1 instruction/cycle on hits with no backpressure.
- Miss: `MC_req` rises on the edge after the lookup. The slot is loaded 2 cycles after `MC_done`: one cycle for the fill write, one for the re-lookup.
- After `ROB_clear` at edge N, the lookup of `ROB_newpc` happens in cycle N+1 and the earliest `IS_ins_sgn` is in cycle N+2.
- When `rdy` is low, no edge changes state, including BHT and `MC_req`. `MC_done` arriving while `rdy` is low is not a legal stimulus.

## Test plan
- **Reset, then miss and hit.** Reset low 2 cycles with mem[0]=0x00500093 (addi).
  - `MC_req`=1 with `MC_addr`=0.
  - After `MC_done`, `IS_ins_sgn`=1 with `IS_ins`=0x00500093 and `IS_jump_pc`=4.
  - A later refetch of 0 hits without `MC_req`.
- **Backpressure.** Slot valid with `ROB_full`=1 for 3 cycles.
  - `IS_ins_sgn`=0 and the slot is unchanged.
  - The instruction is delivered exactly once when `ROB_full`=0.
- **Branch prediction.** Branch at pc 0x10 with B-imm=+8, counter=01.
  - Slot shows `jump_flag`=0, `jump_pc`=0x18; next fetch is 0x14.
  - After two `ROB_br_sgn` taken updates for 0x10 (counter 01→10→11), refetch gives `jump_flag`=1, `jump_pc`=0x14, next fetch 0x18.
- **JAL and JALR.**
  - JAL at 0x20 with imm=+0x100: next `MC_addr`=0x120 and `jump_pc`=0x24.
  - JALR: no fetch until `ROB_clear` with `ROB_newpc`=0x40; then `MC_addr`=0x40.
- **Flush mid-miss.** `ROB_clear` with `ROB_newpc`=0x80 coincident with `MC_done` for 0x4.
  - `MC_req` drops, line 0x4 stays invalid, and the next request is 0x80.
- **`rdy` stall.** `rdy`=0 for 4 cycles during FETCH with the slot valid.
  - `IS_ins_sgn`=0 and `pc` is frozen.
  - Operation resumes identically when `rdy`=1.

Source files
------------

// File: rtl/ifetcher.sv
// Instruction fetch unit. It has a direct-mapped word I-cache, a 2-bit BHT
// for branch prediction, and a single output slot with a valid/accept handshake to issue.
module ifetcher #(
  parameter int unsigned ICACHE_LINES = 256,
  parameter int unsigned BHT_ENTRIES  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ROB_full,
  input  logic        LSB_full,
  input  logic        RS_full,
  output logic        IS_ins_sgn,
  output logic [31:0] IS_ins,
  output logic        IS_jump_flag,
  output logic [31:0] IS_jump_pc,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_data,
  input  logic        ROB_clear,
  input  logic [31:0] ROB_newpc,
  input  logic        ROB_br_sgn,
  input  logic [31:0] ROB_br_pc,
  input  logic        ROB_br_taken
);

  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {S_FETCH, S_MISS, S_JALR_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ins_q, ins_d;
  logic        jflag_q, jflag_d;
  logic [31:0] jpc_q, jpc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        fill_we;

  logic [ICACHE_LINES-1:0] cv_q;
  logic [TAG_W-1:0]        ctag_q  [ICACHE_LINES];
  logic [31:0]             cdata_q [ICACHE_LINES];
  logic [1:0]              bht_q   [BHT_ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [31:0]      fetch_ins;
  logic [6:0]       opcode;
  logic [31:0]      imm_b, imm_j, pc_plus4;
  logic [BHT_W-1:0] bht_idx, br_idx;
  logic             pred_taken;
  logic             slot_free;
  logic             unused_bits;

  // Lookup and predecode of the word at pc
  assign idx        = pc_q[IDX_W+1:2];
  assign tag        = pc_q[31:IDX_W+2];
  assign hit        = cv_q[idx] && (ctag_q[idx] == tag);
  assign fetch_ins  = cdata_q[idx];
  assign opcode     = fetch_ins[6:0];
  assign imm_j      = {{12{fetch_ins[31]}}, fetch_ins[19:12], fetch_ins[20], fetch_ins[30:21], 1'b0};
  assign imm_b      = {{20{fetch_ins[31]}}, fetch_ins[7], fetch_ins[30:25], fetch_ins[11:8], 1'b0};
  assign pc_plus4   = pc_q + 32'd4;
  assign bht_idx    = pc_q[BHT_W+1:2];
  assign br_idx     = ROB_br_pc[BHT_W+1:2];
  assign pred_taken = bht_q[bht_idx][1];
  assign unused_bits = ^{ROB_br_pc[31:BHT_W+2], ROB_br_pc[1:0]};

  assign IS_ins_sgn   = valid_q & rdy & ~ROB_full & ~LSB_full & ~RS_full;
  assign slot_free    = ~valid_q | IS_ins_sgn;
  assign IS_ins       = ins_q;
  assign IS_jump_flag = jflag_q;
  assign IS_jump_pc   = jpc_q;
  assign MC_req       = req_q;
  assign MC_addr      = addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      valid_q <= 1'b0;
      ins_q   <= '0;
      jflag_q <= 1'b0;
      jpc_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ins_q   <= ins_d;
      jflag_q <= jflag_d;
      jpc_q   <= jpc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, slot load and miss handling; a flush overrides everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q & ~IS_ins_sgn;
    ins_d   = ins_q;
    jflag_d = jflag_q;
    jpc_d   = jpc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fill_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!hit) begin
          state_d = S_MISS;
          req_d   = 1'b1;
          addr_d  = {pc_q[31:2], 2'b00};
        end else if (slot_free) begin
          valid_d = 1'b1;
          ins_d   = fetch_ins;
          jflag_d = 1'b0;
          jpc_d   = pc_plus4;
          pc_d    = pc_plus4;
          case (opcode)
            OP_JAL:    pc_d = pc_q + imm_j;
            OP_BRANCH: begin
              if (pred_taken) begin
                pc_d    = pc_q + imm_b;
                jflag_d = 1'b1;
              end else begin
                jpc_d = pc_q + imm_b;
              end
            end
            OP_JALR:   state_d = S_JALR_WAIT;
            OP_AUIPC:  jpc_d = pc_q;
            default:   ;
          endcase
        end
      end
      S_MISS: begin
        if (MC_done) begin
          fill_we = 1'b1;
          req_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_JALR_WAIT: ;
      default: state_d = S_FETCH;
    endcase
    if (ROB_clear) begin
      state_d = S_FETCH;
      pc_d    = ROB_newpc;
      valid_d = 1'b0;
      req_d   = 1'b0;
      fill_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cv_q <= '0;
    end else if (rdy && fill_we) begin
      cv_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (rst && rdy && fill_we) begin
      ctag_q[idx]  <= tag;
      cdata_q[idx] <= MC_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (rdy && ROB_br_sgn) begin
      if (ROB_br_taken && bht_q[br_idx] != 2'b11) bht_q[br_idx] <= bht_q[br_idx] + 2'd1;
      else if (!ROB_br_taken && bht_q[br_idx] != 2'b00) bht_q[br_idx] <= bht_q[br_idx] - 2'd1;
    end
  end

endmodule

// File: tb/tb_ifetcher.sv
// Directed bench for ifetcher. Issued instructions and memory requests are
// checked against expected-value queues that a forked monitor drains.
`timescale 1ns/1ps
module tb_ifetcher;

  localparam logic [31:0] I_ADDI5 = 32'h0050_0093;
  localparam logic [31:0] I_ADDI1 = 32'h0010_0113;
  localparam logic [31:0] I_JALR  = 32'h0000_8067;
  localparam logic [31:0] I_BEQ8  = 32'h0000_0463;
  localparam logic [31:0] I_JAL   = 32'h1000_006F;

  typedef struct packed {
    logic [31:0] ins;
    logic        flag;
    logic [31:0] jpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ROB_full = 1'b0, LSB_full = 1'b0, RS_full = 1'b0;
  logic        IS_ins_sgn;
  logic [31:0] IS_ins;
  logic        IS_jump_flag;
  logic [31:0] IS_jump_pc;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done = 1'b0;
  logic [31:0] MC_data = '0;
  logic        ROB_clear = 1'b0;
  logic [31:0] ROB_newpc = '0;
  logic        ROB_br_sgn = 1'b0;
  logic [31:0] ROB_br_pc = '0;
  logic        ROB_br_taken = 1'b0;

  logic [31:0] mem [0:127];
  exp_t        exp_ins_q [$];
  logic [31:0] exp_req_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_cnt = 0;

  ifetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ROB_full(ROB_full), .LSB_full(LSB_full), .RS_full(RS_full),
    .IS_ins_sgn(IS_ins_sgn), .IS_ins(IS_ins), .IS_jump_flag(IS_jump_flag),
    .IS_jump_pc(IS_jump_pc), .MC_req(MC_req), .MC_addr(MC_addr),
    .MC_done(MC_done), .MC_data(MC_data), .ROB_clear(ROB_clear),
    .ROB_newpc(ROB_newpc), .ROB_br_sgn(ROB_br_sgn), .ROB_br_pc(ROB_br_pc),
    .ROB_br_taken(ROB_br_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ins(input logic [31:0] ins, input logic f, input logic [31:0] jpc);
    exp_t e;
    e.ins = ins; e.flag = f; e.jpc = jpc;
    exp_ins_q.push_back(e);
  endtask

  task automatic wait_req(input string name, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (MC_req === 1'b1);
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s: MC_req never rose within 40 cycles", name);
    end
  endtask

  // Memory controller: answer one pending request with a single MC_done pulse
  task automatic serve(input string name);
    bit got;
    wait_req(name, got);
    if (got) begin
      tick();
      MC_done = 1'b1;
      MC_data = mem[MC_addr[8:2]];
      tick();
      MC_done = 1'b0;
    end
  endtask

  task automatic do_clear(input logic [31:0] npc);
    tick();
    ROB_clear = 1'b1;
    ROB_newpc = npc;
    tick();
    ROB_clear = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done_w;
    done_w = 1'b0;
    for (int k = 0; k < 60 && !done_w; k++) begin
      @(negedge clk);
      done_w = (exp_ins_q.size() == 0);
    end
    if (!done_w) begin
      n_tests++; n_fail++;
      $display("FAIL %s: %0d expected instructions never issued", name, exp_ins_q.size());
    end
  endtask

  initial begin
    bit   got;
    int   rc;
    exp_t e;
    logic req_prev;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[0]  = I_ADDI5; mem[1] = I_ADDI1; mem[2] = I_JALR;
    mem[4]  = I_BEQ8;  mem[5] = I_JALR;  mem[6] = I_JALR;
    mem[8]  = I_JAL;   mem[16] = I_JALR; mem[32] = I_JALR; mem[72] = I_JALR;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_sgn",   32'(IS_ins_sgn), 32'd0);
    chk("rst_ins",   IS_ins, 32'd0);
    chk("rst_flag",  32'(IS_jump_flag), 32'd0);
    chk("rst_jpc",   IS_jump_pc, 32'd0);
    chk("rst_req",   32'(MC_req), 32'd0);
    chk("rst_addr",  MC_addr, 32'd0);
    rst = 1'b1;

    req_prev = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (IS_ins_sgn === 1'b1) begin
          n_tests++;
          if (exp_ins_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got ins %h jpc %h, none expected", IS_ins, IS_jump_pc);
          end else begin
            e = exp_ins_q.pop_front();
            if (IS_ins !== e.ins || IS_jump_flag !== e.flag || IS_jump_pc !== e.jpc) begin
              n_fail++;
              $display("FAIL issue: got ins %h flag %b jpc %h expected ins %h flag %b jpc %h",
                       IS_ins, IS_jump_flag, IS_jump_pc, e.ins, e.flag, e.jpc);
            end
          end
        end
        if (MC_req === 1'b1 && req_prev !== 1'b1) begin
          req_cnt++;
          n_tests++;
          if (exp_req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: got MC_addr %h, no request expected", MC_addr);
          end else if (MC_addr !== exp_req_q[0]) begin
            n_fail++;
            $display("FAIL req_addr: got MC_addr %h expected %h", MC_addr, exp_req_q[0]);
            void'(exp_req_q.pop_front());
          end else begin
            void'(exp_req_q.pop_front());
          end
        end
        req_prev = MC_req;
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Cold miss at 0, then flush coincident with the fill of 0x4
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    push_ins(I_ADDI5, 1'b0, 32'h4);
    serve("miss0");
    wait_req("miss4", got);
    exp_req_q.push_back(32'h80);
    tick();
    MC_done = 1'b1; MC_data = mem[1];
    ROB_clear = 1'b1; ROB_newpc = 32'h80;
    tick();
    MC_done = 1'b0; ROB_clear = 1'b0;
    @(negedge clk);
    chk("flush_req_drop", 32'(MC_req), 32'd0);
    push_ins(I_JALR, 1'b0, 32'h84);
    serve("miss80");
    wait_empty("flush_path");

    // Line 0x4 must still be invalid: refetching it misses again
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    push_ins(I_ADDI1, 1'b0, 32'h8);
    push_ins(I_JALR, 1'b0, 32'hC);
    do_clear(32'h4);
    serve("refill4");
    serve("miss8");
    wait_empty("line4_path");

    // All-hit refetch from 0: back-to-back issue, no memory traffic
    rc = req_cnt;
    push_ins(I_ADDI5, 1'b0, 32'h4);
    push_ins(I_ADDI1, 1'b0, 32'h8);
    push_ins(I_JALR, 1'b0, 32'hC);
    do_clear(32'h0);
    @(negedge clk); chk("clear_n1_sgn", 32'(IS_ins_sgn), 32'd0);
    @(negedge clk); chk("clear_n2_sgn", 32'(IS_ins_sgn), 32'd1);
    @(negedge clk); chk("stream_2_sgn", 32'(IS_ins_sgn), 32'd1);
    @(negedge clk); chk("stream_3_sgn", 32'(IS_ins_sgn), 32'd1);
    @(negedge clk); chk("jalr_stop_sgn", 32'(IS_ins_sgn), 32'd0);
    chk("hit_no_req", 32'(req_cnt), 32'(rc));

    // Backpressure holds the slot for three cycles
    push_ins(I_ADDI5, 1'b0, 32'h4);
    push_ins(I_ADDI1, 1'b0, 32'h8);
    push_ins(I_JALR, 1'b0, 32'hC);
    tick();
    ROB_full = 1'b1;
    do_clear(32'h0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_sgn", 32'(IS_ins_sgn), 32'd0);
      chk("bp_ins", IS_ins, I_ADDI5);
      chk("bp_jpc", IS_jump_pc, 32'h4);
    end
    tick();
    ROB_full = 1'b0;
    wait_empty("bp_release");

    // Branch predicted not-taken with counter 01
    exp_req_q.push_back(32'h10);
    exp_req_q.push_back(32'h14);
    push_ins(I_BEQ8, 1'b0, 32'h18);
    push_ins(I_JALR, 1'b0, 32'h18);
    do_clear(32'h10);
    serve("miss10");
    serve("miss14");
    wait_empty("br_nt");

    // Two taken resolutions move the counter to 11
    tick();
    ROB_br_sgn = 1'b1; ROB_br_pc = 32'h10; ROB_br_taken = 1'b1;
    tick(); tick();
    ROB_br_sgn = 1'b0;
    exp_req_q.push_back(32'h18);
    push_ins(I_BEQ8, 1'b1, 32'h14);
    push_ins(I_JALR, 1'b0, 32'h1C);
    do_clear(32'h10);
    serve("miss18");
    wait_empty("br_t");

    // JAL redirect, then JALR stalls until the flush to 0x40
    exp_req_q.push_back(32'h20);
    exp_req_q.push_back(32'h120);
    push_ins(I_JAL, 1'b0, 32'h24);
    push_ins(I_JALR, 1'b0, 32'h124);
    do_clear(32'h20);
    serve("miss20");
    serve("miss120");
    wait_empty("jal");
    rc = req_cnt;
    repeat (6) @(negedge clk);
    chk("jalr_wait_noreq", 32'(req_cnt), 32'(rc));
    chk("jalr_wait_req", 32'(MC_req), 32'd0);
    exp_req_q.push_back(32'h40);
    push_ins(I_JALR, 1'b0, 32'h44);
    do_clear(32'h40);
    serve("miss40");
    wait_empty("jalr_redirect");

    // rdy low for four cycles with a valid slot in FETCH
    push_ins(I_ADDI5, 1'b0, 32'h4);
    push_ins(I_ADDI1, 1'b0, 32'h8);
    push_ins(I_JALR, 1'b0, 32'hC);
    tick();
    ROB_full = 1'b1;
    do_clear(32'h0);
    @(negedge clk);
    @(negedge clk);
    tick();
    rdy = 1'b0;
    ROB_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rdy_low_sgn", 32'(IS_ins_sgn), 32'd0);
      chk("rdy_low_ins", IS_ins, I_ADDI5);
    end
    tick();
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_resume_sgn", 32'(IS_ins_sgn), 32'd1);
    chk("rdy_resume_ins", IS_ins, I_ADDI5);
    wait_empty("rdy_resume");

    repeat (4) @(negedge clk);
    chk("ins_queue_drained", 32'(exp_ins_q.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
